// File: rtl/fx3_arb_pkg.sv
// Shared definitions for the FX3 slave-FIFO arbiter.
//   arb_state_t          : arbiter state encoding
//   OWNER_RD / OWNER_WR  : last_owner encoding (used for tie-breaking)
//   DEF_RD_ADDR/WR_ADDR  : default consumer / producer socket addresses
//   tmr_width()          : width for a down-counter holding values 0..n-1
package fx3_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_SETUP = 3'd1,
        ARB_RD    = 3'd2,
        ARB_WR    = 3'd3,
        ARB_TURN  = 3'd4
    } arb_state_t;

    localparam logic OWNER_RD = 1'b1;
    localparam logic OWNER_WR = 1'b0;

    localparam logic [1:0] DEF_RD_ADDR = 2'd3;
    localparam logic [1:0] DEF_WR_ADDR = 2'd0;

    // Width of a counter that must hold n-1 (never less than 1 bit).
    function automatic int tmr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fx3_arb_timer.sv
// Loadable down-counter with a zero flag. Once loaded it counts down by one
// per cycle and parks at zero; zero is asserted while the count is 0.
// Ports:
//   clk_100  in  clock (rising edge)
//   reset_   in  asynchronous active-low reset (count -> 0)
//   load     in  load load_val this cycle (takes priority over counting)
//   load_val in  W-bit value to load
//   zero     out count == 0
module fx3_arb_timer #(
    parameter int W = 2
) (
    input  logic         clk_100,
    input  logic         reset_,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fx3_fifo_arbiter.sv
// FX3 slave-FIFO bus arbiter between the stream-OUT read sequencer and the
// stream-IN write sequencer. Drives faddr, holds it stable for ADDR_SETUP
// cycles before granting, inserts TURN_CYC idle cycles after every release,
// lets the other side preempt after MAX_BURST owned cycles, and gates the
// FX3 strobes with the grants.
// Optional build macro: FX3_ARB_STATS_EN adds rd_grant_cnt / wr_grant_cnt.
// Ports:
//   clk_100, reset_                 clock, async active-low reset
//   rd_req, wr_req                  bus requests (held while busy)
//   rd_slrd_, rd_sloe_              read sequencer strobe requests
//   wr_slwr_, wr_pktend_            write sequencer strobe requests
//   rd_gnt, wr_gnt                  registered grants (never both 1)
//   faddr                           registered FX3 FIFO address
//   slrd_, sloe_, slwr_, pktend_    gated FX3 strobes, active-low
//   dq_oe                           FPGA drives dq (only while in ARB_WR)
//   busy                            arbiter not idle
//   rd_grant_cnt, wr_grant_cnt      grant counters (FX3_ARB_STATS_EN only)
module fx3_fifo_arbiter
    import fx3_arb_pkg::*;
#(
    parameter logic [1:0] RD_ADDR    = DEF_RD_ADDR,
    parameter logic [1:0] WR_ADDR    = DEF_WR_ADDR,
    parameter int         ADDR_SETUP = 2,
    parameter int         TURN_CYC   = 3,
    parameter int         MAX_BURST  = 1024,
    parameter int         BURST_W    = 11
) (
    input  logic       clk_100,
    input  logic       reset_,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic       rd_slrd_,
    input  logic       rd_sloe_,
    input  logic       wr_slwr_,
    input  logic       wr_pktend_,
    output logic       rd_gnt,
    output logic       wr_gnt,
    output logic [1:0] faddr,
    output logic       slrd_,
    output logic       sloe_,
    output logic       slwr_,
    output logic       pktend_,
    output logic       dq_oe,
    output logic       busy
`ifdef FX3_ARB_STATS_EN
   ,output logic [15:0] rd_grant_cnt,
    output logic [15:0] wr_grant_cnt
`endif
);

    localparam int TMR_MAX = (ADDR_SETUP > TURN_CYC) ? ADDR_SETUP : TURN_CYC;
    localparam int TMR_W   = tmr_width(TMR_MAX);

    // The timer is loaded with N-1 on the entry edge: the state then lasts
    // N cycles, leaving on the edge where the timer already reads zero.
    localparam logic [TMR_W-1:0]   SETUP_LOAD = TMR_W'(ADDR_SETUP - 1);
    localparam logic [TMR_W-1:0]   TURN_LOAD  = TMR_W'(TURN_CYC - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    arb_state_t          state;
    logic                cur_rd;      // side being set up / owning the bus
    logic                last_owner;
    logic [BURST_W-1:0]  burst_cnt;

    logic own_req, other_req, burst_full, pick_rd;
    logic setup_go, grant_go, to_turn;
    logic tmr_load, tmr_zero;
    logic [TMR_W-1:0] tmr_val;

    assign own_req    = cur_rd ? rd_req : wr_req;
    assign other_req  = cur_rd ? wr_req : rd_req;
    assign burst_full = (burst_cnt == BURST_LAST);
    // On a tie the side that did not own the bus last goes first.
    assign pick_rd    = rd_req && (!wr_req || (last_owner == OWNER_WR));

    assign setup_go = (state == ARB_IDLE) && (rd_req || wr_req);
    assign to_turn  = ((state == ARB_SETUP) && !own_req) ||
                      (((state == ARB_RD) || (state == ARB_WR)) &&
                       (!own_req || (burst_full && other_req)));
    assign grant_go = (state == ARB_SETUP) && own_req && tmr_zero;

    assign tmr_load = setup_go || to_turn;
    assign tmr_val  = setup_go ? SETUP_LOAD : TURN_LOAD;

    fx3_arb_timer #(.W(TMR_W)) u_timer (
        .clk_100  (clk_100),
        .reset_   (reset_),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            state      <= ARB_IDLE;
            cur_rd     <= 1'b0;
            last_owner <= OWNER_WR;
            burst_cnt  <= '0;
            rd_gnt     <= 1'b0;
            wr_gnt     <= 1'b0;
            dq_oe      <= 1'b0;
            faddr      <= WR_ADDR;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (setup_go) begin
                        state  <= ARB_SETUP;
                        cur_rd <= pick_rd;
                        faddr  <= pick_rd ? RD_ADDR : WR_ADDR;
                    end
                end
                ARB_SETUP: begin
                    if (to_turn) begin
                        state <= ARB_TURN;
                    end else if (grant_go) begin
                        burst_cnt <= '0;
                        if (cur_rd) begin
                            state      <= ARB_RD;
                            rd_gnt     <= 1'b1;
                            last_owner <= OWNER_RD;
                        end else begin
                            state      <= ARB_WR;
                            wr_gnt     <= 1'b1;
                            dq_oe      <= 1'b1;
                            last_owner <= OWNER_WR;
                        end
                    end
                end
                ARB_RD, ARB_WR: begin
                    if (to_turn) begin
                        state  <= ARB_TURN;
                        rd_gnt <= 1'b0;
                        wr_gnt <= 1'b0;
                        dq_oe  <= 1'b0;
                    end else if (!burst_full) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                ARB_TURN: begin
                    if (tmr_zero)
                        state <= ARB_IDLE;
                end
                default: begin
                    state  <= ARB_IDLE;
                    rd_gnt <= 1'b0;
                    wr_gnt <= 1'b0;
                    dq_oe  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes pass only while the matching grant is held; reset clears the
    // grants asynchronously so every strobe goes high at once.
    assign slrd_   = rd_gnt ? rd_slrd_   : 1'b1;
    assign sloe_   = rd_gnt ? rd_sloe_   : 1'b1;
    assign slwr_   = wr_gnt ? wr_slwr_   : 1'b1;
    assign pktend_ = wr_gnt ? wr_pktend_ : 1'b1;

    assign busy = (state != ARB_IDLE);

`ifdef FX3_ARB_STATS_EN
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            rd_grant_cnt <= '0;
            wr_grant_cnt <= '0;
        end else if (grant_go) begin
            if (cur_rd) rd_grant_cnt <= rd_grant_cnt + 16'd1;
            else        wr_grant_cnt <= wr_grant_cnt + 16'd1;
        end
    end
`endif

endmodule
